// File: rtl/alu_ctrl_exec_if.sv
// Request/response bundle for alu_ctrl_exec.
//   master: decode-stage side (drives request, consumes result)
//   slave : the ALU execute block
// Request : in_valid/in_ready, alu_op, funct, shamt, src_a, src_b
// Response: out_valid/out_ready, result, alu_ctrl, zero, overflow, illegal
interface alu_ctrl_exec_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         alu_op;
  logic [5:0]         funct;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   src_a;
  logic [WIDTH-1:0]   src_b;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic [3:0]         alu_ctrl;
  logic               zero;
  logic               overflow;
  logic               illegal;

  modport master (
    output in_valid, alu_op, funct, shamt, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, alu_ctrl, zero, overflow, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct, shamt, src_a, src_b, out_ready,
    output in_ready, out_valid, result, alu_ctrl, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_ctrl_exec.sv
// ALU control decode merged with a registered execute stage.
// Decodes ALUOp/funct to the 4-bit ALU control code, executes on WIDTH-bit
// operands and holds the result until the consumer takes it. Shifts run
// iteratively, one bit per cycle.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - alu_ctrl_exec_if.slave (request in, registered result out)
module alu_ctrl_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic            clk,
  input logic            reset,
  alu_ctrl_exec_if.slave bus
);

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_NOR = 4'b0100;
  localparam logic [3:0] C_SLL = 4'b0101;
  localparam logic [3:0] C_SRL = 4'b0110;
  localparam logic [3:0] C_ILL = 4'b0111;
  localparam logic [3:0] C_SUB = 4'b1010;
  localparam logic [3:0] C_SLT = 4'b1011;
  localparam logic [3:0] C_SRA = 4'b1110;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       ill;
    logic       sovf;   // signed add/sub: overflow is reported
    logic       shift;
  } dec_t;

  state_t state, state_nxt;
  dec_t   dec;

  logic               in_ready, accept;
  logic [WIDTH-1:0]   a, b, sum, dif, alu_res, shift_nxt;
  logic               alu_ovf;
  logic [WIDTH-1:0]   res_q;   // doubles as the shift register
  logic [3:0]         ctrl_q;
  logic               zero_q, ovf_q, ill_q;
  logic [SHAMT_W-1:0] cnt_q;

  assign a        = bus.src_a;
  assign b        = bus.src_b;
  assign in_ready = (state == IDLE) && !reset;
  assign accept   = bus.in_valid && in_ready;

  // ALUOp / funct decode
  always_comb begin
    dec = '{ctrl: C_ILL, ill: 1'b0, sovf: 1'b0, shift: 1'b0};
    case (bus.alu_op)
      3'b000: dec.ctrl = C_AND;
      3'b001: dec.ctrl = C_OR;
      3'b010: dec.ctrl = C_NOR;
      3'b011: begin dec.ctrl = C_ADD; dec.sovf = 1'b1; end
      3'b100: begin dec.ctrl = C_SUB; dec.sovf = 1'b1; end
      3'b101: dec.ctrl = C_SLT;
      3'b111: begin
        case (bus.funct)
          6'b100100: dec.ctrl = C_AND;
          6'b100101: dec.ctrl = C_OR;
          6'b100000: begin dec.ctrl = C_ADD; dec.sovf = 1'b1; end
          6'b100001: dec.ctrl = C_ADD;
          6'b100010: begin dec.ctrl = C_SUB; dec.sovf = 1'b1; end
          6'b100011: dec.ctrl = C_SUB;
          6'b101010: dec.ctrl = C_SLT;
          6'b100111: dec.ctrl = C_NOR;
          6'b000000: begin dec.ctrl = C_SLL; dec.shift = 1'b1; end
          6'b000010: begin dec.ctrl = C_SRL; dec.shift = 1'b1; end
          6'b000011: begin dec.ctrl = C_SRA; dec.shift = 1'b1; end
          default:   dec.ill = 1'b1;
        endcase
      end
      default: dec.ill = 1'b1;
    endcase
  end

  // Single-cycle ops; illegal falls through to result 0
  assign sum = a + b;
  assign dif = a - b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (dec.ctrl)
      C_AND: alu_res = a & b;
      C_OR:  alu_res = a | b;
      C_NOR: alu_res = ~(a | b);
      C_ADD: begin
        alu_res = sum;
        alu_ovf = dec.sovf && (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      C_SUB: begin
        alu_res = dif;
        alu_ovf = dec.sovf && (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      C_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // One-bit step of the iterative shifter
  always_comb begin
    case (ctrl_q)
      C_SRL:   shift_nxt = {1'b0, res_q[WIDTH-1:1]};
      C_SRA:   shift_nxt = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
      default: shift_nxt = {res_q[WIDTH-2:0], 1'b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept)
               state_nxt = (dec.shift && bus.shamt != '0) ? SHIFT : DONE;
      SHIFT: if (cnt_q == SHAMT_W'(1)) state_nxt = DONE;
      DONE:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q  <= '0;
      ctrl_q <= C_ILL;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      ill_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          ctrl_q <= dec.ctrl;
          ill_q  <= dec.ill;
          if (dec.shift) begin
            res_q  <= b;
            cnt_q  <= bus.shamt;
            ovf_q  <= 1'b0;
            zero_q <= (b == '0);
          end else begin
            res_q  <= alu_res;
            ovf_q  <= alu_ovf;
            zero_q <= (alu_res == '0);
          end
        end
        // zero tracks each step so it is already right on the final one
        SHIFT: begin
          res_q  <= shift_nxt;
          cnt_q  <= cnt_q - SHAMT_W'(1);
          zero_q <= (shift_nxt == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Randomised + directed bench for alu_ctrl_exec against a behavioural model.
module tb_alu_ctrl_exec;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_ctrl_exec_if #(.WIDTH(W)) bus();
  alu_ctrl_exec #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef enum {K_AND, K_OR, K_NOR, K_ADD, K_ADDU, K_SUB, K_SUBU,
                K_SLT, K_SLL, K_SRL, K_SRA, K_ILL} kind_t;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  ctrl;
    logic        z;
    logic        ov;
    logic        ill;
    logic [6:0]  lat;
  } exp_t;

  int   checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  bit   pending = 0, seen = 0;
  exp_t ex;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Outcome of one op from the instruction-set rules, using wide signed math
  function automatic exp_t model(input logic [2:0] op, input logic [5:0] f,
                                 input logic [4:0] sh, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t   e;
    kind_t  k;
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    k  = K_ILL;
    case (op)
      3'd0: k = K_AND;
      3'd1: k = K_OR;
      3'd2: k = K_NOR;
      3'd3: k = K_ADD;
      3'd4: k = K_SUB;
      3'd5: k = K_SLT;
      3'd7: case (f)
        6'h24: k = K_AND;  6'h25: k = K_OR;   6'h20: k = K_ADD;
        6'h21: k = K_ADDU; 6'h22: k = K_SUB;  6'h23: k = K_SUBU;
        6'h2a: k = K_SLT;  6'h27: k = K_NOR;  6'h00: k = K_SLL;
        6'h02: k = K_SRL;  6'h03: k = K_SRA;
        default: k = K_ILL;
      endcase
      default: k = K_ILL;
    endcase
    e = '0;
    e.lat = 7'd1;
    t = 0;
    case (k)
      K_AND: begin e.res = a & b;    e.ctrl = 4'b0000; end
      K_OR:  begin e.res = a | b;    e.ctrl = 4'b0001; end
      K_NOR: begin e.res = ~(a | b); e.ctrl = 4'b0100; end
      K_ADD, K_ADDU: begin
        t = sa + sb; e.res = t[31:0]; e.ctrl = 4'b0010;
        e.ov = (k == K_ADD) && (t > 64'sd2147483647 || t < -64'sd2147483648);
      end
      K_SUB, K_SUBU: begin
        t = sa - sb; e.res = t[31:0]; e.ctrl = 4'b1010;
        e.ov = (k == K_SUB) && (t > 64'sd2147483647 || t < -64'sd2147483648);
      end
      K_SLT: begin e.res = (sa < sb) ? 32'd1 : 32'd0; e.ctrl = 4'b1011; end
      K_SLL: begin e.res = b << sh; e.ctrl = 4'b0101; e.lat = 7'(sh) + 7'd1; end
      K_SRL: begin e.res = b >> sh; e.ctrl = 4'b0110; e.lat = 7'(sh) + 7'd1; end
      K_SRA: begin e.res = 32'($signed(b) >>> sh); e.ctrl = 4'b1110; e.lat = 7'(sh) + 7'd1; end
      default: begin e.res = '0; e.ctrl = 4'b0111; e.ill = 1'b1; end
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  // Single compare process: every cycle out_valid is meaningful
  always @(negedge clk) begin
    if (!reset) begin
      if (pending && bus.out_valid) begin
        if (!seen) begin
          chk("latency", 64'(cyc - acc_cyc), 64'(ex.lat));
          seen = 1;
        end
        chk("result",   bus.result,   ex.res);
        chk("alu_ctrl", bus.alu_ctrl, ex.ctrl);
        chk("zero",     bus.zero,     ex.z);
        chk("overflow", bus.overflow, ex.ov);
        chk("illegal",  bus.illegal,  ex.ill);
      end else if (!pending) begin
        chk("idle_out_valid", bus.out_valid, 1'b0);
      end
    end
  end

  // Called at posedge+#1 with the DUT idle; returns one cycle after accept
  task automatic issue(input logic [2:0] op, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    bus.alu_op = op; bus.funct = f; bus.shamt = sh;
    bus.src_a = a; bus.src_b = b; bus.in_valid = 1'b1;
    ex = model(op, f, sh, a, b);
    seen = 0; pending = 1; acc_cyc = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait for the result, hold it bp cycles under backpressure, then take it
  task automatic finish_op(input int bp);
    int n = 0;
    while (!bus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("out_valid_timeout", bus.out_valid, 1'b1);
    for (int i = 0; i < bp; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.alu_op = 3'($urandom); bus.funct = 6'($urandom); bus.shamt = 5'($urandom);
      bus.src_a = $urandom; bus.src_b = $urandom;
      @(negedge clk);
      chk("in_ready_in_done", bus.in_ready, 1'b0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    pending = 0;
    chk("in_ready_after_done", bus.in_ready, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  logic [31:0] corner [4];
  initial begin
    corner[0] = 32'h0; corner[1] = 32'h7FFFFFFF;
    corner[2] = 32'h80000000; corner[3] = 32'hFFFFFFFF;
  end

  initial begin
    logic [5:0] legal [11];
    logic [2:0] op;
    logic [5:0] f;
    logic [31:0] a, b;
    legal = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h22, 6'h23, 6'h2a, 6'h27, 6'h00, 6'h02, 6'h03};

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.alu_op = '0; bus.funct = '0; bus.shamt = '0; bus.src_a = '0; bus.src_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_ready_during_reset", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result",    bus.result,    32'h0);
    chk("rst_alu_ctrl",  bus.alu_ctrl,  4'b0111);
    chk("rst_zero",      bus.zero,      1'b0);
    chk("rst_overflow",  bus.overflow,  1'b0);
    chk("rst_illegal",   bus.illegal,   1'b0);
    chk("rst_in_ready",  bus.in_ready,  1'b1);

    // signed add overflow, then unsigned add of the same operands
    issue(3'b111, 6'h20, 5'd0, 32'h7FFFFFFF, 32'd1);
    chk("pin_add_res", ex.res, 32'h80000000);
    chk("pin_add_ovf", ex.ov, 1'b1);
    chk("pin_add_ctrl", ex.ctrl, 4'b0010);
    finish_op(0);
    issue(3'b111, 6'h21, 5'd0, 32'h7FFFFFFF, 32'd1);
    chk("pin_addu_ovf", ex.ov, 1'b0);
    finish_op(0);
    issue(3'b100, 6'h00, 5'd0, 32'd5, 32'd5);
    chk("pin_sub_zero", ex.z, 1'b1);
    chk("pin_sub_ctrl", ex.ctrl, 4'b1010);
    finish_op(1);

    // worst-case shifts
    issue(3'b111, 6'h03, 5'd31, 32'h0, 32'h80000000);
    chk("pin_sra_res", ex.res, 32'hFFFFFFFF);
    chk("pin_sra_lat", ex.lat, 7'd32);
    finish_op(0);
    issue(3'b111, 6'h02, 5'd31, 32'h0, 32'h80000000);
    chk("pin_srl_res", ex.res, 32'h00000001);
    finish_op(0);
    issue(3'b111, 6'h00, 5'd0, 32'h0, 32'h1234);
    chk("pin_sll0_res", ex.res, 32'h1234);
    chk("pin_sll0_lat", ex.lat, 7'd1);
    finish_op(0);
    issue(3'b101, 6'h00, 5'd0, 32'hFFFFFFFF, 32'd1);
    chk("pin_slt_res", ex.res, 32'd1);
    finish_op(0);

    // backpressure: 5 cycles held in DONE with junk requests
    issue(3'b000, 6'h00, 5'd0, 32'h0000F0F0, 32'h0000FF00);
    chk("pin_and_res", ex.res, 32'h0000F000);
    finish_op(5);

    // illegal funct
    issue(3'b111, 6'b001000, 5'd0, 32'h1, 32'h2);
    chk("pin_ill_ctrl", ex.ctrl, 4'b0111);
    chk("pin_ill_flag", ex.ill, 1'b1);
    finish_op(0);

    // reset during SHIFT cycle 3 of sll by 10 abandons the op
    issue(3'b111, 6'h00, 5'd10, 32'h0, 32'h1);
    repeat (2) begin @(posedge clk); #1; end
    pending = 0;
    reset = 1'b1;
    #1;
    chk("in_ready_reset_midshift", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("in_ready_after_reset", bus.in_ready, 1'b1);
    chk("alu_ctrl_after_reset", bus.alu_ctrl, 4'b0111);
    repeat (12) begin @(posedge clk); #1; end

    // randomised ops
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) op = 3'b111;
      f = ($urandom_range(0, 9) != 0) ? legal[$urandom_range(0, 10)] : 6'($urandom);
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      issue(op, f, 5'($urandom), a, b);
      finish_op($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_exec.md
# alu_ctrl_exec

Parametrised successor to the combinational ALU control decoder, merged with a registered execute stage. The block decodes ALUOp/funct into the existing 4-bit ALU control code and executes the operation on WIDTH-bit operands. It adds srl/sra, unsigned add/sub, overflow and illegal-op flags, and an iterative one-bit-per-cycle shifter behind a valid/ready handshake. It sits between the decode stage and writeback in the multi-cycle datapath.

## Interface
- WIDTH, 32, operand/result width (power of two, ≥8)
- SHAMT_W, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
- clk  in  1  clock; single clock domain, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept; equals (state==IDLE && !reset)
- alu_op  in  3  ALUOp from main control
- funct  in  6  instruction funct field (used only when alu_op==111)
- shamt  in  SHAMT_W  shift amount
- src_a  in  WIDTH  operand A (rs)
- src_b  in  WIDTH  operand B (rt / immediate; shift source)
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- alu_ctrl  out  4  registered decoded control code of the current/last op
- zero  out  1  result==0
- overflow  out  1  signed overflow (add/sub only)
- illegal  out  1  undecodable alu_op/funct

## Operation
- Decode, alu_op: 000 and(0000), 001 or(0001), 011 add(0010), 100 sub(1010), 101 slt(1011), 010 nor(0100), 110 illegal, 111 R-type by funct.
- R-type funct: 100100 and, 100101 or, 100000 add, 100001 addu(0010), 100010 sub, 100011 subu(1010), 101010 slt, 100111 nor, 000000 sll(0101), 000010 srl(0110), 000011 sra(1110); any other -> illegal.
- Illegal: alu_ctrl=0111, result=0, zero=1, illegal=1, overflow=0.
- Arithmetic is modulo 2^WIDTH; add/sub carries are discarded.
- overflow is set only for alu_op 011/100 and funct 100000/100010, using two's-complement rules. It is 0 for addu/subu and all other ops.
- slt is a signed compare; the result is 1 or 0, zero-extended to WIDTH.
- Shifts operate on src_b by shamt. srl fills with 0; sra replicates the MSB.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on in_valid && in_ready, latch the decode and operands.
  - Non-shift op: compute result, go to DONE.
  - Shift op: load shreg=src_b and cnt=shamt. Go to DONE if shamt==0, else to SHIFT.
  - SHIFT: shift shreg one bit per cycle and decrement cnt. When cnt==1, the shreg update is final and the next state is DONE.
  - DONE: out_valid=1; result and flags are stable. On out_ready, go to IDLE.
- Inputs are ignored outside IDLE. in_ready does not depend on out_ready.

## Timing
- Accept at cycle N:
  - Non-shift op: out_valid from N+1.
  - Shift by k: SHIFT occupies N+1..N+k; out_valid from N+1+k (k=0 gives N+1).
- Worst-case latency is WIDTH cycles (k=WIDTH-1).
- Back-to-back throughput is one op per 2 cycles minimum: the DONE->IDLE handshake takes one cycle, and the next accept happens in IDLE.
- out_valid stays high with result, alu_ctrl and flags unchanged until out_ready is sampled high. The result drops at the next edge.
- Reset value of every output:
  - out_valid=0, result=0, alu_ctrl=0111, zero=0, overflow=0, illegal=0.
  - in_ready=0 during the reset cycle and 1 in the first cycle after.
- Reset asserted mid-SHIFT or in DONE abandons the op: no out_valid, state returns to IDLE. Reset overrides a simultaneous in_valid.
- Registered outputs only; no combinational path from inputs to result/flags.

## Test plan
- Reset, then R-type add (funct 100000), src_a=0x7FFFFFFF, src_b=1 -> out_valid at N+1, result=0x80000000, overflow=1, alu_ctrl=0010, zero=0.
- Same operands with addu (100001) -> result=0x80000000, overflow=0. Then sub of 5-5 (alu_op 100) -> result=0, zero=1, alu_ctrl=1010.
- sra, src_b=0x80000000, shamt=31 -> out_valid exactly at N+32, result=0xFFFFFFFF, alu_ctrl=1110. srl with the same operands -> result=0x00000001.
- sll, shamt=0, src_b=0x1234 -> out_valid at N+1, result=0x1234, alu_ctrl=0101. slt with src_a=-1, src_b=1 -> result=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result and flags stable, in_ready=0, in_valid pulses ignored. Release -> IDLE on the next cycle.
- funct=001000 (alu_op 111) -> illegal=1, alu_ctrl=0111, result=0. Separately, reset asserted at SHIFT cycle 3 of an sll by 10 -> no out_valid, in_ready=1 the cycle after reset deasserts.
